montexp_kary: RTL and testbench

MONTEXP_KARY -- requirements
Module: montexp_kary

---
 rtl/montexp_kary.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_montexp_kary.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/montexp_kary.sv
// Left-to-right k-ary Montgomery exponentiation built around one word-serial CIOS multiplier.
// Define MONTEXP_CONST_TIME_EN for the exponent-independent (no window skipping) schedule.

module montcios #(
  parameter int WIDTH = 32,
  parameter int S     = 8,
  parameter int N     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH*S-1:0] a_i,
  input  logic [WIDTH*S-1:0] b_i,
  input  logic [WIDTH*S-1:0] p_i,
  input  logic [WIDTH-1:0]   p_prime_i,
  output logic [WIDTH*S-1:0] r_o,
  output logic               done_o
);
  localparam int OW = WIDTH * S;
  localparam int TW = OW + WIDTH + 2;
  localparam int CW = $clog2(S + N + 2);
  localparam logic [CW-1:0] LIMBS = CW'(S);
  localparam logic [CW-1:0] LAST  = CW'(S + N);

  logic          run_q, run_d, done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] aSh_q, aSh_d, r_q, r_d;
  logic [TW-1:0] t_q, t_d, u, v, pExt;
  logic [WIDTH-1:0] m;

  // One limb of a per cycle; t stays below 2p, so a single final subtraction reduces it.
  // N extra cycles pad the latency after the reduction.
  assign pExt = {{(TW-OW){1'b0}}, p_i};
  assign u = t_q + ({{(TW-WIDTH){1'b0}}, aSh_q[WIDTH-1:0]} * {{(TW-OW){1'b0}}, b_i});
  assign m = u[WIDTH-1:0] * p_prime_i;
  assign v = u + ({{(TW-WIDTH){1'b0}}, m} * pExt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q  <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      aSh_q  <= '0;
      r_q    <= '0;
      t_q    <= '0;
    end else begin
      run_q  <= run_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      aSh_q  <= aSh_d;
      r_q    <= r_d;
      t_q    <= t_d;
    end
  end

  always_comb begin
    run_d  = run_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    aSh_d  = aSh_q;
    t_d    = t_q;
    r_d    = r_q;
    if (!run_q) begin
      if (start_i) begin
        run_d = 1'b1;
        cnt_d = '0;
        aSh_d = a_i;
        t_d   = '0;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q < LIMBS) begin
        t_d   = v >> WIDTH;
        aSh_d = aSh_q >> WIDTH;
      end
      if (cnt_q == LIMBS)
        r_d = (t_q >= pExt) ? (t_q[OW-1:0] - p_i) : t_q[OW-1:0];
      if (cnt_q == LAST) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  assign r_o    = r_q;
  assign done_o = done_q;
endmodule

module montexp_kary #(
  parameter int WIDTH  = 32,
  parameter int S      = 8,
  parameter int EWIDTH = 256,
  parameter int K      = 4,
  parameter int N      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH*S-1:0] base_i,
  input  logic [EWIDTH-1:0]  exponent_i,
  input  logic [WIDTH*S-1:0] modulus_i,
  input  logic [WIDTH-1:0]   p_prime_i,
  input  logic [WIDTH*S-1:0] mont_one_i,
  output logic               busy_o,
  output logic [WIDTH*S-1:0] result_o,
  output logic               done_o
);
  localparam int OW  = WIDTH * S;
  localparam int TN  = 1 << K;
  localparam int NW  = EWIDTH / K;
  localparam int IW  = K + 1;
  localparam int WW  = $clog2(NW + 1);
  localparam int SQW = $clog2(K + 1);
`ifdef MONTEXP_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  if (K < 1 || K > 6 || (EWIDTH % K) != 0) begin : gBadK
    $error("montexp_kary: K must be 1..6 and divide EWIDTH");
  end

  typedef enum logic [2:0] {IDLE, PRECOMP, SCAN, SQUARE, MULT, FINISH} state_t;

  state_t           state_q, state_d;
  logic [EWIDTH-1:0] expSh_q, expSh_d;
  logic [OW-1:0]    mod_q, mod_d, acc_q, acc_d, opA_q, opA_d, opB_q, opB_d;
  logic [OW-1:0]    result_q, result_d;
  logic [OW-1:0]    tbl_q [TN];
  logic [OW-1:0]    tbl_d [TN];
  logic [WIDTH-1:0] pp_q, pp_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WW-1:0]    win_q, win_d;
  logic [SQW-1:0]   sq_q, sq_d;
  logic             lead_q, lead_d, pend_q, pend_d, mulStart_q, mulStart_d;
  logic [K-1:0]     win, idxPrev;
  logic [OW-1:0]    mulR;
  logic             mulDone;

  montcios #(.WIDTH(WIDTH), .S(S), .N(N)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mulStart_q),
    .a_i       (opA_q),
    .b_i       (opB_q),
    .p_i       (mod_q),
    .p_prime_i (pp_q),
    .r_o       (mulR),
    .done_o    (mulDone)
  );

  // The exponent is consumed by shifting, so the current window is always the top K bits.
  assign win     = expSh_q[EWIDTH-1 -: K];
  assign idxPrev = idx_q[K-1:0] - K'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      expSh_q    <= '0;
      mod_q      <= '0;
      acc_q      <= '0;
      opA_q      <= '0;
      opB_q      <= '0;
      result_q   <= '0;
      pp_q       <= '0;
      idx_q      <= '0;
      win_q      <= '0;
      sq_q       <= '0;
      lead_q     <= 1'b0;
      pend_q     <= 1'b0;
      mulStart_q <= 1'b0;
      for (int i = 0; i < TN; i++) tbl_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      expSh_q    <= expSh_d;
      mod_q      <= mod_d;
      acc_q      <= acc_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      result_q   <= result_d;
      pp_q       <= pp_d;
      idx_q      <= idx_d;
      win_q      <= win_d;
      sq_q       <= sq_d;
      lead_q     <= lead_d;
      pend_q     <= pend_d;
      mulStart_q <= mulStart_d;
      tbl_q      <= tbl_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    expSh_d    = expSh_q;
    mod_d      = mod_q;
    acc_d      = acc_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    result_d   = result_q;
    pp_d       = pp_q;
    idx_d      = idx_q;
    win_d      = win_q;
    sq_d       = sq_q;
    lead_d     = lead_q;
    pend_d     = pend_q;
    mulStart_d = 1'b0;
    tbl_d      = tbl_q;
    case (state_q)
      IDLE, FINISH: begin
        state_d = IDLE;
        if (start_i) begin
          state_d  = PRECOMP;
          expSh_d  = exponent_i;
          mod_d    = modulus_i;
          pp_d     = p_prime_i;
          tbl_d[0] = mont_one_i;
          tbl_d[1] = base_i;
          acc_d    = mont_one_i;
          idx_d    = IW'(2);
          win_d    = '0;
          lead_d   = !CONST_TIME;
          pend_d   = 1'b0;
        end
      end
      PRECOMP: begin
        if (!pend_q) begin
          if (idx_q == IW'(TN)) state_d = SCAN;
          else begin
            opA_d      = tbl_q[idxPrev];
            opB_d      = tbl_q[1];
            mulStart_d = 1'b1;
            pend_d     = 1'b1;
          end
        end else if (mulDone) begin
          tbl_d[idx_q[K-1:0]] = mulR;
          idx_d  = idx_q + IW'(1);
          pend_d = 1'b0;
        end
      end
      SCAN: begin
        if (win_q == WW'(NW)) begin
          result_d = acc_q;
          state_d  = FINISH;
        end else if (lead_q) begin
          // Leading windows: skip zeros, load the first nonzero one straight from the table.
          if (win != '0) begin
            acc_d  = tbl_q[win];
            lead_d = 1'b0;
          end
          expSh_d = expSh_q << K;
          win_d   = win_q + WW'(1);
        end else begin
          sq_d    = '0;
          state_d = SQUARE;
        end
      end
      SQUARE: begin
        if (!pend_q) begin
          if (sq_q == SQW'(K)) state_d = MULT;
          else begin
            opA_d      = acc_q;
            opB_d      = acc_q;
            mulStart_d = 1'b1;
            pend_d     = 1'b1;
          end
        end else if (mulDone) begin
          acc_d  = mulR;
          sq_d   = sq_q + SQW'(1);
          pend_d = 1'b0;
        end
      end
      MULT: begin
        if (!pend_q) begin
          if (win == '0 && !CONST_TIME) begin
            expSh_d = expSh_q << K;
            win_d   = win_q + WW'(1);
            state_d = SCAN;
          end else begin
            opA_d      = acc_q;
            opB_d      = tbl_q[win];
            mulStart_d = 1'b1;
            pend_d     = 1'b1;
          end
        end else if (mulDone) begin
          acc_d   = mulR;
          pend_d  = 1'b0;
          expSh_d = expSh_q << K;
          win_d   = win_q + WW'(1);
          state_d = SCAN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o   = (state_q != IDLE) && (state_q != FINISH);
  assign done_o   = (state_q == FINISH);
  assign result_o = result_q;
endmodule

// File: tb/tb_montexp_kary.sv
// Randomized self-checking bench for montexp_kary (WIDTH=16, S=2, EWIDTH=16, K=4) against a modular-arithmetic model.
// Honours MONTEXP_CONST_TIME_EN when the design is built with it.

module tb_montexp_kary;
  localparam int WIDTH = 16, S = 2, EWIDTH = 16, K = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        startI;
  logic [31:0] baseI, modI, oneI, resultO;
  logic [15:0] expI, ppI;
  logic        busyO, doneO;

  int checks = 0, errors = 0;
  int startCnt = 0, doneCnt = 0;

  montexp_kary #(.WIDTH(WIDTH), .S(S), .EWIDTH(EWIDTH), .K(K), .N(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (startI),
    .base_i     (baseI),
    .exponent_i (expI),
    .modulus_i  (modI),
    .p_prime_i  (ppI),
    .mont_one_i (oneI),
    .busy_o     (busyO),
    .result_o   (resultO),
    .done_o     (doneO)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dut.u_mul.start_i) startCnt++;
    if (doneO) doneCnt++;
  end

  // Reference model: plain modular arithmetic with R = 2^32.
  function automatic longint unsigned powMod(input longint unsigned b, input logic [15:0] e,
                                             input longint unsigned p);
    longint unsigned r;
    r = 64'd1 % p;
    for (int i = 15; i >= 0; i--) begin
      r = (r * r) % p;
      if (e[i]) r = (r * (b % p)) % p;
    end
    return r;
  endfunction

  function automatic logic [31:0] toMont(input longint unsigned x, input longint unsigned p);
    return 32'(((x % p) << 32) % p);
  endfunction

  function automatic logic [15:0] negInv(input logic [31:0] p);
    logic [31:0] inv;
    inv = p;
    for (int i = 0; i < 5; i++) inv = inv * (32'd2 - p * inv);
    return 16'(32'd0 - inv);
  endfunction

  function automatic int expectedMults(input logic [15:0] e);
`ifdef MONTEXP_CONST_TIME_EN
    return 14 + 4 * 5 + 0 * int'(e[0]);
`else
    int n;
    bit seen;
    logic [3:0] w;
    n = 14;
    seen = 1'b0;
    for (int j = 0; j < 4; j++) begin
      w = e[15 - 4*j -: 4];
      if (seen) n += 4 + ((w != 4'd0) ? 1 : 0);
      else if (w != 4'd0) seen = 1'b1;
    end
    return n;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one start pulse; caller must already be at a negedge.
  task automatic applyStimulus(input logic [31:0] p, input logic [31:0] b, input logic [15:0] e);
    baseI  = toMont(64'(b), 64'(p));
    expI   = e;
    modI   = p;
    ppI    = negInv(p);
    oneI   = toMont(64'd1, 64'(p));
    startI = 1'b1;
    @(negedge clk);
    startI = 1'b0;
  endtask

  task automatic waitDone(input string tag, output int lat);
    bit ok;
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      lat++;
      if (doneO) ok = 1'b1;
    end
    if (!ok) checkOutput({tag, " timeout"}, 64'd0, 64'd1);
  endtask

  function automatic logic [31:0] expected(input logic [31:0] p, input logic [31:0] b, input logic [15:0] e);
    return toMont(powMod(64'(b), e, 64'(p)), 64'(p));
  endfunction

  task automatic runOp(input string tag, input logic [31:0] p, input logic [31:0] b,
                       input logic [15:0] e, output int lat);
    int s0, d0;
    s0 = startCnt;
    d0 = doneCnt;
    @(negedge clk);
    applyStimulus(p, b, e);
    waitDone(tag, lat);
    checkOutput({tag, " result"}, 64'(resultO), 64'(expected(p, b, e)));
    checkOutput({tag, " starts"}, 64'(startCnt - s0), 64'(expectedMults(e)));
    checkOutput({tag, " busy@done"}, 64'(busyO), 64'd0);
    @(negedge clk);
    checkOutput({tag, " donePulses"}, 64'(doneCnt - d0), 64'd1);
    checkOutput({tag, " doneLow"}, 64'(doneO), 64'd0);
  endtask

  initial begin
    logic [31:0] p, b, p2, b2;
    logic [15:0] e, e2;
    int lat0, lat1, lat2, s0, d0;
    bit reached;

    rst = 1'b1; startI = 1'b0;
    baseI = '0; expI = '0; modI = '0; ppI = '0; oneI = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 64'(busyO), 64'd0);
    checkOutput("reset done", 64'(doneO), 64'd0);
    checkOutput("reset result", 64'(resultO), 64'd0);
    rst = 1'b0;

    p = 32'hF123_4567; b = 32'h1234_5678;
    runOp("exp0000", p, b, 16'h0000, lat0);
    runOp("exp0001", p, b, 16'h0001, lat1);
    runOp("exp0010", p, b, 16'h0010, lat1);
    runOp("expFFFF", p, b, 16'hFFFF, lat2);
`ifdef MONTEXP_CONST_TIME_EN
    checkOutput("ct latency 0010 vs 0000", 64'(lat1), 64'(lat0));
    checkOutput("ct latency FFFF vs 0000", 64'(lat2), 64'(lat0));
`endif

    for (int i = 0; i < 6; i++) begin
      p = $urandom | 32'h8000_0001;
      b = $urandom % p;
      e = 16'($urandom_range(0, 65535));
      runOp($sformatf("rand%0d", i), p, b, e, lat0);
    end

    // Second start while busy must be ignored; the changed inputs must not leak in.
    p = $urandom | 32'h0000_0001; b = $urandom % p; e = 16'hFFFF;
    s0 = startCnt; d0 = doneCnt;
    @(negedge clk);
    applyStimulus(p, b, e);
    repeat (20) @(negedge clk);
    applyStimulus(p ^ 32'h0000_0100, b ^ 32'h5A5A_0000, 16'h0001);
    waitDone("busyStart", lat0);
    checkOutput("busyStart result", 64'(resultO), 64'(expected(p, b, e)));
    checkOutput("busyStart starts", 64'(startCnt - s0), 64'(expectedMults(e)));
    repeat (400) @(negedge clk);
    checkOutput("busyStart donePulses", 64'(doneCnt - d0), 64'd1);
    checkOutput("busyStart idle", 64'(busyO), 64'd0);

    // Start presented in the done cycle is accepted.
    p  = $urandom | 32'h8000_0001; b  = $urandom % p;  e  = 16'($urandom_range(1, 65535));
    p2 = $urandom | 32'h4000_0001; b2 = $urandom % p2; e2 = 16'($urandom_range(1, 65535));
    @(negedge clk);
    applyStimulus(p, b, e);
    waitDone("chain1", lat0);
    checkOutput("chain1 result", 64'(resultO), 64'(expected(p, b, e)));
    s0 = startCnt;
    applyStimulus(p2, b2, e2);
    checkOutput("chain2 accepted", 64'(busyO), 64'd1);
    waitDone("chain2", lat0);
    checkOutput("chain2 result", 64'(resultO), 64'(expected(p2, b2, e2)));
    checkOutput("chain2 starts", 64'(startCnt - s0), 64'(expectedMults(e2)));

    // Reset in the middle of the squaring phase.
    p = 32'hC0DE_F00D | 32'h1; b = 32'h0BAD_CAFE; e = 16'hFFFF;
    s0 = startCnt;
    @(negedge clk);
    applyStimulus(p, b, e);
    reached = 1'b0;
    for (int i = 0; i < 2000 && !reached; i++) begin
      @(negedge clk);
      if (startCnt - s0 >= 15) reached = 1'b1;
    end
    checkOutput("midReset reachedSquare", 64'(reached), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midReset busy", 64'(busyO), 64'd0);
    checkOutput("midReset done", 64'(doneO), 64'd0);
    checkOutput("midReset result", 64'(resultO), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    d0 = doneCnt;
    repeat (400) @(negedge clk);
    checkOutput("midReset noStaleDone", 64'(doneCnt - d0), 64'd0);
    runOp("afterReset", p, b, 16'hA5C3, lat0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
